mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit: the consumer end of the execute-to-memory pipeline register.
- Takes the registered ALU result, store data and control, and runs loads/stores on a req/ack data-memory bus.
- Stalls the upstream pipeline while a transaction is outstanding.
- Registers the writeback-stage signals (result, destination register, write enable) for the register file.

---
 rtl/mem_stage_lsu.sv | 137 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a req/ack data bus, stalls upstream while busy, registers writeback.
// Optional MEM_TIMEOUT_EN: aborts a transaction after 255 unacknowledged wait cycles and raises timeoutW_o.
module mem_stage_lsu #(
  parameter int DATA_WIDTH             = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              validM_i,
  input  logic [DATA_WIDTH-1:0]             ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]             RD2M_i,
  input  logic                              ResultSrcM_i,
  input  logic                              MemWriteM_i,
  input  logic                              regWriteM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3M_i,
  output logic                              stallM_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [DATA_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  input  logic                              mem_ack_i,
  output logic [DATA_WIDTH-1:0]             ResultW_o,
  output logic                              regWriteW_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] AD3W_o,
`ifdef MEM_TIMEOUT_EN
  output logic                              timeoutW_o,
`endif
  output logic                              misalignW_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                              r_state, w_next;
  logic                                r_req, r_we, r_rw, r_misal;
  logic [DATA_WIDTH-1:0]               r_addr, r_wdata, r_result;
  logic [REGISTER_ADDRESS_WIDTH-1:0]   r_ad3;
  logic                                w_memop, w_aligned, w_issue, w_abort;

  assign w_memop   = validM_i & (ResultSrcM_i | MemWriteM_i);
  assign w_aligned = (ALUResultM_i[1:0] == 2'b00);
  assign w_issue   = w_memop & w_aligned;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_timeout;
  assign w_abort    = (r_state == BUSY) & ~mem_ack_i & (r_cnt == 8'hFF);
  assign timeoutW_o = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == IDLE) r_cnt <= '0;
      else if (!mem_ack_i) r_cnt <= r_cnt + 8'd1;
      if (w_abort) r_timeout <= 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next = BUSY;
      BUSY:    if (mem_ack_i || w_abort) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stallM_o = 1'b0;
    case (r_state)
      IDLE:    stallM_o = w_issue;
      BUSY:    stallM_o = ~mem_ack_i & ~w_abort;
      default: stallM_o = 1'b0;
    endcase
  end

  // Bus and writeback registers; every stalled cycle retires a bubble so a load writes exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= 1'b0; r_we <= 1'b0; r_addr <= '0; r_wdata <= '0;
      r_result <= '0; r_rw <= 1'b0; r_ad3 <= '0; r_misal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_memop) begin
            r_result <= ALUResultM_i;
            r_rw     <= validM_i & regWriteM_i;
            r_ad3    <= AD3M_i;
          end else if (w_aligned) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteM_i;
            r_addr  <= {ALUResultM_i[DATA_WIDTH-1:2], 2'b00};
            r_wdata <= RD2M_i;
            r_rw    <= 1'b0;
          end else begin
            r_misal <= 1'b1;
            r_rw    <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            r_req    <= 1'b0;
            r_result <= ResultSrcM_i ? mem_rdata_i : ALUResultM_i;
            r_rw     <= regWriteM_i;
            r_ad3    <= AD3M_i;
          end else if (w_abort) begin
            r_req <= 1'b0;
            r_rw  <= 1'b0;
          end else begin
            r_rw <= 1'b0;
          end
        end
        default: r_rw <= 1'b0;
      endcase
    end
  end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign ResultW_o   = r_result;
  assign regWriteW_o = r_rw;
  assign AD3W_o      = r_ad3;
  assign misalignW_o = r_misal;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected writebacks queued at issue, popped when regWriteW_o fires.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        validM_i, ResultSrcM_i, MemWriteM_i, regWriteM_i;
  logic [31:0] ALUResultM_i, RD2M_i, mem_rdata_i;
  logic [4:0]  AD3M_i;
  logic        mem_ack_i;
  logic        stallM_o, mem_req_o, mem_we_o, regWriteW_o, misalignW_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ResultW_o;
  logic [4:0]  AD3W_o;
`ifdef MEM_TIMEOUT_EN
  logic        timeoutW_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .validM_i(validM_i), .ALUResultM_i(ALUResultM_i),
    .RD2M_i(RD2M_i), .ResultSrcM_i(ResultSrcM_i), .MemWriteM_i(MemWriteM_i),
    .regWriteM_i(regWriteM_i), .AD3M_i(AD3M_i), .stallM_o(stallM_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .ResultW_o(ResultW_o), .regWriteW_o(regWriteW_o), .AD3W_o(AD3W_o),
`ifdef MEM_TIMEOUT_EN
    .timeoutW_o(timeoutW_o),
`endif
    .misalignW_o(misalignW_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    validM_i = 0; ResultSrcM_i = 0; MemWriteM_i = 0; regWriteM_i = 0;
    ALUResultM_i = '0; RD2M_i = '0; AD3M_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic rw,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    validM_i = 1; ResultSrcM_i = ld; MemWriteM_i = st; regWriteM_i = rw;
    ALUResultM_i = a; RD2M_i = d; AD3M_i = rd;
  endtask

  // Writeback monitor: every regWriteW_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && regWriteW_o) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("wb_result", ResultW_o, e[36:5]);
        chk("wb_ad3", {27'd0, AD3W_o}, {27'd0, e[4:0]});
      end
    end
  end

  initial begin
    int n;
    idle_in();
    rst = 1;
    step(); step();
    chk("rst_req",  {31'd0, mem_req_o}, 0);
    chk("rst_rw",   {31'd0, regWriteW_o}, 0);
    chk("rst_res",  ResultW_o, 0);
    chk("rst_mis",  {31'd0, misalignW_o}, 0);
    chk("rst_stall",{31'd0, stallM_o}, 0);
    rst = 0;

    // ALU op
    drive(0, 0, 1, 32'h0000_1234, 0, 5'd5);
    #1 chk("alu_stall", {31'd0, stallM_o}, 0);
    sb_q.push_back({32'h0000_1234, 5'd5});
    step(); idle_in();
    chk("alu_rw", {31'd0, regWriteW_o}, 1);
    step();
    chk("alu_rw_once", {31'd0, regWriteW_o}, 0);

    // Load with 3 wait cycles
    drive(1, 0, 1, 32'h100, 0, 5'd7);
    n = 0;
    #1 if (stallM_o) n++;
    step();
    chk("ld_req",  {31'd0, mem_req_o}, 1);
    chk("ld_addr", mem_addr_o, 32'h100);
    chk("ld_we",   {31'd0, mem_we_o}, 0);
    for (int i = 0; i < 3; i++) begin
      if (stallM_o) n++;
      chk("ld_hold_addr", mem_addr_o, 32'h100);
      step();
    end
    mem_ack_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    #1 chk("ld_ack_stall", {31'd0, stallM_o}, 0);
    chk("ld_stall_cnt", n, 4);
    sb_q.push_back({32'hDEAD_BEEF, 5'd7});
    step(); idle_in();
    chk("ld_req_drop", {31'd0, mem_req_o}, 0);
    chk("ld_rw", {31'd0, regWriteW_o}, 1);
    step();
    chk("ld_rw_once", {31'd0, regWriteW_o}, 0);

    // Store, ack in first request cycle
    drive(0, 1, 0, 32'h204, 32'hA5A5_A5A5, 5'd9);
    #1 chk("st_stall0", {31'd0, stallM_o}, 1);
    step();
    chk("st_we",    {31'd0, mem_we_o}, 1);
    chk("st_wdata", mem_wdata_o, 32'hA5A5_A5A5);
    chk("st_addr",  mem_addr_o, 32'h204);
    mem_ack_i = 1;
    #1 chk("st_stall1", {31'd0, stallM_o}, 0);
    step(); idle_in();
    chk("st_rw", {31'd0, regWriteW_o}, 0);
    step();

    // Back-to-back loads
    drive(1, 0, 1, 32'h10, 0, 5'd3);
    step();
    mem_ack_i = 1; mem_rdata_i = 32'h1111_1111;
    sb_q.push_back({32'h1111_1111, 5'd3});
    step();
    drive(1, 0, 1, 32'h14, 0, 5'd4);
    mem_ack_i = 0;
    chk("b2b_ad3_1", {27'd0, AD3W_o}, 3);
    #1 chk("b2b_stall", {31'd0, stallM_o}, 1);
    step();
    chk("b2b_req2",  {31'd0, mem_req_o}, 1);
    chk("b2b_addr2", mem_addr_o, 32'h14);
    mem_ack_i = 1; mem_rdata_i = 32'h2222_2222;
    sb_q.push_back({32'h2222_2222, 5'd4});
    step(); idle_in();
    chk("b2b_ad3_2", {27'd0, AD3W_o}, 4);
    step();

    // Misaligned load
    drive(1, 0, 1, 32'h102, 0, 5'd6);
    #1 chk("mis_stall", {31'd0, stallM_o}, 0);
    step(); idle_in();
    chk("mis_req", {31'd0, mem_req_o}, 0);
    chk("mis_flag", {31'd0, misalignW_o}, 1);
    chk("mis_rw", {31'd0, regWriteW_o}, 0);
    step(); step();
    chk("mis_sticky", {31'd0, misalignW_o}, 1);

`ifdef MEM_TIMEOUT_EN
    drive(1, 0, 1, 32'h300, 0, 5'd2);
    step();
    n = 0;
    while (stallM_o && n < 400) begin n++; step(); end
    chk("to_wait_cycles", n, 255);
    step(); idle_in();
    chk("to_flag", {31'd0, timeoutW_o}, 1);
    chk("to_req", {31'd0, mem_req_o}, 0);
    step();
`endif

    // Reset mid-transaction; later ack ignored
    drive(1, 0, 1, 32'h40, 0, 5'd8);
    step();
    chk("rb_req", {31'd0, mem_req_o}, 1);
    rst = 1;
    step();
    rst = 0; idle_in();
    chk("rb_req0", {31'd0, mem_req_o}, 0);
    chk("rb_mis0", {31'd0, misalignW_o}, 0);
    chk("rb_res0", ResultW_o, 0);
    mem_ack_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
    #1 chk("rb_stall", {31'd0, stallM_o}, 0);
    step(); mem_ack_i = 0;
    chk("rb_rw", {31'd0, regWriteW_o}, 0);
    chk("rb_req_after", {31'd0, mem_req_o}, 0);
    step();

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
